// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg
// Shared types and constants for the pipeline hazard/stall controller.
//   tuse_t / tnew_t : 2-bit operand-need and result-ready times
//   slot_t          : tracked pipeline slot {wreg, tnew}
//   TUSE_NONE       : tuse encoding meaning "operand not read"
//   MULT_CYC_DEF / DIV_CYC_DEF : default mult/div occupancy
package stall_ctrl_pkg;

    typedef logic [1:0] tuse_t;
    typedef logic [1:0] tnew_t;
    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t wreg;
        tnew_t    tnew;
    } slot_t;

    localparam tuse_t       TUSE_NONE    = 2'd3;
    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    // A slot blocks an operand when it will write that register later than the
    // operand is needed. $0 is hard-wired and never blocks.
    function automatic logic reg_hazard(reg_idx_t op, tuse_t tuse, slot_t s);
        return (tuse != TUSE_NONE) && (op != '0) && (op == s.wreg) && (s.tnew > tuse);
    endfunction

    // Saturating decrement: a ready result stays ready.
    function automatic tnew_t tnew_dec(tnew_t t);
        return (t == '0) ? '0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_cnt.sv
// md_busy_cnt
// Load/decrement counter tracking how long the mult/div unit stays occupied.
//   clk_i      : core clock
//   rstn_i     : asynchronous active-low reset
//   load_i     : a mult/div is leaving E this cycle; reload the counter
//   load_val_i : occupancy in cycles for the operation being loaded
//   busy_o     : counter non-zero
module md_busy_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl
// Hazard and stall controller for the five-stage core. Tracks the destination
// register and remaining Tnew of the instructions in E and M, compares them with
// the Tuse of the D instruction, and freezes F/D while clearing E on a hazard.
// Optional feature macro: STALL_CTRL_MD_EN adds the mult/div busy counter and
// the HI/LO hazard; without it the md inputs are ignored and busy is 0.
// Ports:
//   stall_ctrl_clk_i / stall_ctrl_rstn_i : clock, async active-low reset
//   stall_ctrl_rs_D_i, stall_ctrl_rt_D_i : D source registers
//   stall_ctrl_tuses_D_i, stall_ctrl_tuset_D_i : cycles until rs/rt needed (3 = unused)
//   stall_ctrl_wreg_D_i, stall_ctrl_tnew_D_i  : D destination and its Tnew
//   stall_ctrl_mds_D_i, stall_ctrl_mdd_D_i    : D starts mult/div; 1 = div
//   stall_ctrl_mdu_D_i                         : D uses the mult/div unit
//   stall_ctrl_stall_o : hold PC and D register
//   stall_ctrl_eclr_o  : clear E register (same as stall)
//   stall_ctrl_busy_o  : mult/div unit busy
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       stall_ctrl_clk_i,
    input  logic       stall_ctrl_rstn_i,
    input  logic [4:0] stall_ctrl_rs_D_i,
    input  logic [4:0] stall_ctrl_rt_D_i,
    input  logic [1:0] stall_ctrl_tuses_D_i,
    input  logic [1:0] stall_ctrl_tuset_D_i,
    input  logic [4:0] stall_ctrl_wreg_D_i,
    input  logic [1:0] stall_ctrl_tnew_D_i,
    input  logic       stall_ctrl_mds_D_i,
    input  logic       stall_ctrl_mdd_D_i,
    input  logic       stall_ctrl_mdu_D_i,
    output logic       stall_ctrl_stall_o,
    output logic       stall_ctrl_eclr_o,
    output logic       stall_ctrl_busy_o
);

    slot_t e_q, m_q;
    logic  haz_reg, haz_md, stall;

    always_comb begin
        haz_reg = reg_hazard(stall_ctrl_rs_D_i, stall_ctrl_tuses_D_i, e_q) |
                  reg_hazard(stall_ctrl_rt_D_i, stall_ctrl_tuset_D_i, e_q) |
                  reg_hazard(stall_ctrl_rs_D_i, stall_ctrl_tuses_D_i, m_q) |
                  reg_hazard(stall_ctrl_rt_D_i, stall_ctrl_tuset_D_i, m_q);
    end

`ifdef STALL_CTRL_MD_EN
    logic e_mds_q, e_mdd_q, md_busy;

    md_busy_cnt #(
        .CNT_W (CNT_W)
    ) u_md_busy_cnt (
        .clk_i      (stall_ctrl_clk_i),
        .rstn_i     (stall_ctrl_rstn_i),
        .load_i     (e_mds_q),
        .load_val_i (e_mdd_q ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC)),
        .busy_o     (md_busy)
    );

    // A mult/div still in E has not loaded the counter yet but already owns HI/LO.
    assign haz_md = stall_ctrl_mdu_D_i & (md_busy | e_mds_q);

    always_ff @(posedge stall_ctrl_clk_i or negedge stall_ctrl_rstn_i) begin
        if (!stall_ctrl_rstn_i) begin
            e_mds_q <= 1'b0;
            e_mdd_q <= 1'b0;
        end else if (stall) begin
            e_mds_q <= 1'b0;
            e_mdd_q <= 1'b0;
        end else begin
            e_mds_q <= stall_ctrl_mds_D_i;
            e_mdd_q <= stall_ctrl_mdd_D_i;
        end
    end

    assign stall_ctrl_busy_o = md_busy;
`else
    logic unused_md;
    localparam int unsigned unused_cfg = MULT_CYC + DIV_CYC + CNT_W;

    assign unused_md         = ^{stall_ctrl_mds_D_i, stall_ctrl_mdd_D_i, stall_ctrl_mdu_D_i};
    assign haz_md            = 1'b0;
    assign stall_ctrl_busy_o = 1'b0;
`endif

    assign stall              = haz_reg | haz_md;
    assign stall_ctrl_stall_o = stall;
    assign stall_ctrl_eclr_o  = stall;

    always_ff @(posedge stall_ctrl_clk_i or negedge stall_ctrl_rstn_i) begin
        if (!stall_ctrl_rstn_i) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            // A stalled D instruction stays in D; E receives a bubble.
            e_q <= stall ? slot_t'('0) : slot_t'({stall_ctrl_wreg_D_i, stall_ctrl_tnew_D_i});
            m_q <= '{wreg: e_q.wreg, tnew: tnew_dec(e_q.tnew)};
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl
// Scoreboarded bench: the driver computes expected outputs from a history of
// issued instructions (absolute issue cycle, Tnew, mult/div kind) and queues
// them; a monitor on the falling edge pops and compares.
module tb_stall_ctrl;

`ifdef STALL_CTRL_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam int MULT_L = 5;
    localparam int DIV_L  = 10;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] rs, rt, wreg;
    logic [1:0] tus, tut, tnew;
    logic       mds, mdd, mdu;
    logic       stall, eclr, busy;

    stall_ctrl dut (
        .stall_ctrl_clk_i     (clk),
        .stall_ctrl_rstn_i    (rstn),
        .stall_ctrl_rs_D_i    (rs),
        .stall_ctrl_rt_D_i    (rt),
        .stall_ctrl_tuses_D_i (tus),
        .stall_ctrl_tuset_D_i (tut),
        .stall_ctrl_wreg_D_i  (wreg),
        .stall_ctrl_tnew_D_i  (tnew),
        .stall_ctrl_mds_D_i   (mds),
        .stall_ctrl_mdd_D_i   (mdd),
        .stall_ctrl_mdu_D_i   (mdu),
        .stall_ctrl_stall_o   (stall),
        .stall_ctrl_eclr_o    (eclr),
        .stall_ctrl_busy_o    (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tus;
        logic [1:0] tut;
        logic [4:0] wr;
        logic [1:0] tn;
        logic       mds;
        logic       mdd;
        logic       mdu;
    } din_t;

    // Issued instruction: c = cycle in which it sits in E.
    typedef struct {
        int         c;
        logic [4:0] wreg;
        int         tnew;
        bit         mds;
        bit         mdd;
    } ent_t;

    typedef struct {
        logic stall;
        logic busy;
        int   cyc;
    } exp_t;

    ent_t hist[$];
    exp_t expq[$];
    int   now = 0;
    int   errors = 0;
    int   checks = 0;
    bit   last_stall = 1'b0;

    function automatic din_t mk(int a, int b, int ta, int tb, int w, int tn_v,
                                bit s, bit d, bit u);
        din_t r;
        r.rs = 5'(a); r.rt = 5'(b); r.tus = 2'(ta); r.tut = 2'(tb);
        r.wr = 5'(w); r.tn = 2'(tn_v); r.mds = s; r.mdd = d; r.mdu = u;
        return r;
    endfunction

    // Cycles of Tnew left for an instruction that entered E at cycle c.
    function automatic int remaining(ent_t e);
        int r;
        r = e.tnew - (now - e.c);
        return (r < 0) ? 0 : r;
    endfunction

    // Unit busy: the most recent mult/div that has left E still has cycles left.
    function automatic bit model_busy();
        int  lc = -1000;
        int  ll = 0;
        foreach (hist[i]) begin
            if (hist[i].mds && hist[i].c < now && hist[i].c > lc) begin
                lc = hist[i].c;
                ll = hist[i].mdd ? DIV_L : MULT_L;
            end
        end
        return (now - lc) >= 1 && (now - lc) <= ll;
    endfunction

    task automatic cyc(input din_t d, input bit pulse_rst);
        bit   st;
        bit   bz;
        bit   e_md;
        exp_t x;
        ent_t n;
        @(posedge clk);
        #1;
        now++;
        rs = d.rs; rt = d.rt; tus = d.tus; tut = d.tut; wreg = d.wr; tnew = d.tn;
        mds = d.mds; mdd = d.mdd; mdu = d.mdu;
        if (pulse_rst) begin
            #2;
            rstn = 1'b0;
            hist.delete();
        end
        while (hist.size() > 0 && hist[0].c < now - 16) void'(hist.pop_front());
        st   = 1'b0;
        e_md = 1'b0;
        foreach (hist[i]) begin
            if (hist[i].c == now || hist[i].c == now - 1) begin
                if (d.rs != 0 && d.rs == hist[i].wreg && remaining(hist[i]) > int'(d.tus)) st = 1'b1;
                if (d.rt != 0 && d.rt == hist[i].wreg && remaining(hist[i]) > int'(d.tut)) st = 1'b1;
            end
            if (hist[i].c == now && hist[i].mds) e_md = 1'b1;
        end
        bz = MD_EN ? model_busy() : 1'b0;
        if (MD_EN && d.mdu && (bz || e_md)) st = 1'b1;
        x.stall = st;
        x.busy  = bz;
        x.cyc   = now;
        expq.push_back(x);
        if (!st) begin
            n.c = now + 1; n.wreg = d.wr; n.tnew = int'(d.tn);
            n.mds = MD_EN && d.mds; n.mdd = d.mdd;
            hist.push_back(n);
        end
        last_stall = st;
        if (pulse_rst) begin
            #4;
            rstn = 1'b1;
        end
    endtask

    // Present one D instruction and hold it while it is stalled.
    task automatic issue(input din_t d, input bit pulse_rst);
        int n = 0;
        cyc(d, pulse_rst);
        while (last_stall && n < 20) begin
            cyc(d, 1'b0);
            n++;
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks += 3;
                if (stall !== e.stall) begin
                    errors++;
                    $display("FAIL stall cyc=%0d got=%b want=%b", e.cyc, stall, e.stall);
                end
                if (eclr !== e.stall) begin
                    errors++;
                    $display("FAIL eclr cyc=%0d got=%b want=%b", e.cyc, eclr, e.stall);
                end
                if (busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy cyc=%0d got=%b want=%b", e.cyc, busy, e.busy);
                end
            end
        end
    end

    initial begin
        din_t d, nop, lw, add;
        nop = mk(0, 0, 3, 3, 0, 0, 0, 0, 0);
        rs = '0; rt = '0; tus = 2'd3; tut = 2'd3; wreg = '0; tnew = '0;
        mds = 1'b0; mdd = 1'b0; mdu = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        lw  = mk(0, 0, 3, 3, 8, 2, 0, 0, 0);
        add = mk(8, 0, 0, 3, 9, 1, 0, 0, 0);
        issue(nop, 1'b1);                                   // reset with empty pipe
        issue(lw, 1'b0);  issue(add, 1'b0);                 // 2-cycle load-use
        issue(mk(0, 0, 3, 3, 8, 1, 0, 0, 0), 1'b0);         // addu $t0
        issue(mk(8, 0, 0, 3, 0, 0, 0, 0, 0), 1'b0);         // beq on $t0: 1 stall
        issue(mk(0, 0, 3, 3, 0, 1, 0, 0, 0), 1'b0);         // write to $0
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);         // $0 never stalls
        issue(mk(0, 0, 3, 3, 10, 1, 0, 0, 0), 1'b0);
        issue(mk(0, 10, 3, 1, 0, 0, 0, 0, 0), 1'b0);        // tnew=1, tuse=1: none
        issue(mk(0, 0, 3, 3, 0, 0, 1, 0, 1), 1'b0);         // mult
        issue(mk(0, 0, 3, 3, 8, 1, 0, 0, 1), 1'b0);         // mflo
        issue(mk(0, 0, 3, 3, 0, 0, 1, 1, 1), 1'b0);         // div
        issue(mk(0, 0, 3, 3, 8, 1, 0, 0, 1), 1'b0);         // mflo
        issue(lw, 1'b0);  cyc(add, 1'b0); issue(add, 1'b1); // reset mid-stall
        repeat (3) issue(nop, 1'b0);

        for (int i = 0; i < 700; i++) begin
            if (!last_stall) begin
                d.rs  = 5'($urandom_range(0, 3)) + (($urandom_range(0, 3) != 0) ? 5'd7 : 5'd0);
                d.rt  = 5'($urandom_range(0, 3)) + (($urandom_range(0, 3) != 0) ? 5'd7 : 5'd0);
                d.rs  = (d.rs == 5'd7) ? 5'd0 : d.rs;
                d.rt  = (d.rt == 5'd7) ? 5'd0 : d.rt;
                d.tus = 2'($urandom_range(0, 3));
                d.tut = 2'($urandom_range(0, 3));
                d.wr  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'd7 + 5'($urandom_range(1, 3));
                d.tn  = 2'($urandom_range(0, 3));
                d.mds = ($urandom_range(0, 11) == 0);
                d.mdd = 1'($urandom_range(0, 1));
                d.mdu = d.mds | ($urandom_range(0, 4) == 0);
            end
            cyc(d, $urandom_range(0, 79) == 0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
